// File: rtl/pwm_duty_controller_if.sv
// Front-panel buttons and PWM period strobe into the duty controller, committed duty back out.
// master = panel/PWM-counter side, slave = pwm_duty_controller.
interface pwm_duty_controller_if;
    logic        RightButton;
    logic        LeftButton;
    logic        SeventyF_button;
    logic        twentyF_button;
    logic        period_end;
    logic [6:0]  duty_pct;
    logic [26:0] duty_compare;
    logic        duty_commit;
    logic        pending;

    modport master (
        output RightButton, LeftButton, SeventyF_button, twentyF_button, period_end,
        input  duty_pct, duty_compare, duty_commit, pending
    );

    modport slave (
        input  RightButton, LeftButton, SeventyF_button, twentyF_button, period_end,
        output duty_pct, duty_compare, duty_commit, pending
    );
endinterface

// File: rtl/pwm_duty_controller.sv
// Debounced button sequencer holding a 0-100 % duty setpoint, committed to the PWM only at period_end.
// Optional feature macro: PWM_CTRL_AUTOREPEAT_EN (held Right/Left re-steps every REPEAT_CYCLES).
module pwm_duty_controller #(
    parameter int PERIOD_CYCLES   = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int STEP_PCT        = 10,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  restart_n,
    pwm_duty_controller_if.slave  ctl
);
    localparam int               UNIT      = PERIOD_CYCLES / 100;
    localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0]      UNIT_W    = 27'(UNIT);
    localparam logic [26:0]      RESET_CMP = 27'(50 * UNIT);
    localparam logic [7:0]       STEP      = 8'(STEP_PCT);

    // Marker block that only elaborates for an unusable parameter set.
    if ((PERIOD_CYCLES % 100) != 0 || PERIOD_CYCLES > 134217727 ||
        DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_params_invalid
        logic params_invalid;
        assign params_invalid = 1'b1;
    end

    typedef enum logic [1:0] {IDLE, QUALIFY, APPLY, WAIT_RELEASE} state_t;
    // Encoding doubles as the bit index into the synchronized button vector.
    typedef enum logic [1:0] {CMD_LEFT, CMD_RIGHT, CMD_TWENTY, CMD_SEVENTY} cmd_t;

    logic [3:0]       raw;
    logic [3:0]       sync;
    state_t           state_reg;
    cmd_t             cmd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [6:0]       shadow_pct;
    logic [6:0]       duty_pct_reg;
    logic [26:0]      duty_compare_reg;
    logic             duty_commit_reg;

    assign raw = {ctl.SeventyF_button, ctl.twentyF_button, ctl.RightButton, ctl.LeftButton};

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_sync
        logic meta_reg;
        logic sync_reg;
        always_ff @(posedge clk or negedge restart_n) begin
            if (!restart_n) begin
                meta_reg <= 1'b0;
                sync_reg <= 1'b0;
            end else begin
                meta_reg <= raw[gi];
                sync_reg <= meta_reg;
            end
        end
        assign sync[gi] = sync_reg;
    end

    function automatic logic [6:0] apply_cmd(input cmd_t cmd, input logic [6:0] cur);
        logic [7:0] cur8;
        logic [7:0] res;
        cur8 = {1'b0, cur};
        case (cmd)
            CMD_SEVENTY: res = 8'd70;
            CMD_TWENTY:  res = 8'd20;
            CMD_RIGHT:   res = (cur8 + STEP > 8'd100) ? 8'd100 : cur8 + STEP;
            default:     res = (cur8 < STEP) ? 8'd0 : cur8 - STEP;
        endcase
        return res[6:0];
    endfunction

`ifdef PWM_CTRL_AUTOREPEAT_EN
    localparam int               REP_W    = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_cnt_reg;
`endif

    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            state_reg  <= IDLE;
            cmd_reg    <= CMD_LEFT;
            cnt_reg    <= '0;
            shadow_pct <= 7'd50;
`ifdef PWM_CTRL_AUTOREPEAT_EN
            rep_cnt_reg <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|sync) begin
                        if (sync[3])      cmd_reg <= CMD_SEVENTY;
                        else if (sync[2]) cmd_reg <= CMD_TWENTY;
                        else if (sync[1]) cmd_reg <= CMD_RIGHT;
                        else              cmd_reg <= CMD_LEFT;
                        cnt_reg   <= '0;
                        state_reg <= QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (!sync[cmd_reg])          state_reg <= IDLE;
                    else if (cnt_reg == DEB_LAST) state_reg <= APPLY;
                    else                          cnt_reg   <= cnt_reg + 1'b1;
                end
                APPLY: begin
                    shadow_pct <= apply_cmd(cmd_reg, shadow_pct);
                    cnt_reg    <= '0;
                    state_reg  <= WAIT_RELEASE;
`ifdef PWM_CTRL_AUTOREPEAT_EN
                    rep_cnt_reg <= '0;
`endif
                end
                default: begin
                    // Release is only accepted after a full debounce window with every button low.
                    if (|sync) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DEB_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
`ifdef PWM_CTRL_AUTOREPEAT_EN
                    if ((cmd_reg == CMD_RIGHT || cmd_reg == CMD_LEFT) && sync[cmd_reg]) begin
                        if (rep_cnt_reg == REP_LAST) begin
                            rep_cnt_reg <= '0;
                            shadow_pct  <= apply_cmd(cmd_reg, shadow_pct);
                        end else begin
                            rep_cnt_reg <= rep_cnt_reg + 1'b1;
                        end
                    end else begin
                        rep_cnt_reg <= '0;
                    end
`endif
                end
            endcase
        end
    end

    // Commit samples the registered shadow, so an APPLY on the same edge waits a period.
    always_ff @(posedge clk or negedge restart_n) begin
        if (!restart_n) begin
            duty_pct_reg     <= 7'd50;
            duty_compare_reg <= RESET_CMP;
            duty_commit_reg  <= 1'b0;
        end else if (ctl.period_end && (shadow_pct != duty_pct_reg)) begin
            duty_pct_reg     <= shadow_pct;
            duty_compare_reg <= 27'(shadow_pct) * UNIT_W;
            duty_commit_reg  <= 1'b1;
        end else begin
            duty_commit_reg  <= 1'b0;
        end
    end

    assign ctl.duty_pct     = duty_pct_reg;
    assign ctl.duty_compare = duty_compare_reg;
    assign ctl.duty_commit  = duty_commit_reg;
    assign ctl.pending      = (shadow_pct != duty_pct_reg);
endmodule
